// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial ripple adder, one full-adder stage per clock, LSB first
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, sum_q, sum_d;
  logic             c_q, c_d, cout_q, cout_d, busy_q, busy_d, done_q, done_d;
  logic             s_bit, c_bit;
  logic [WIDTH-1:0] r_shift;

  always_comb begin
    s_bit   = a_q[0] ^ b_q[0] ^ c_q;
    c_bit   = (a_q[0] & b_q[0]) | (b_q[0] & c_q) | (a_q[0] & c_q);
    r_shift = {s_bit, r_q[WIDTH-1:1]};

    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    r_d     = r_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = done_q;

    case (state_q)
      IDLE, DONE: begin
        done_d = 1'b0;
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      RUN: begin
        // start is deliberately not looked at here
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = c_bit;
        r_d   = r_shift;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = r_shift;
          cout_d  = c_bit;
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      r_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      r_q     <= r_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized self-checking bench for serial_adder against a+b+cin
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int total = 0;
  int bad   = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    int unsigned t;
    t = int'(x) + int'(y) + int'(ci);
    return t[W:0];
  endfunction

  // One operation from an idle/done state; edges counts the start edge through the done edge.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        output logic [W:0] res, output int edges, output int busy_n,
                        output int unstable, output logic done_after);
    logic [W-1:0] prev_s;
    logic         prev_c;
    logic         seen;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb; cin = tc;
    prev_s = sum; prev_c = cout;
    @(posedge clk);
    edges = 1; busy_n = 0; unstable = 0; seen = 1'b0;
    #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    for (int k = 0; k < 4 * W; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_n++;
      if (sum !== prev_s || cout !== prev_c) unstable++;
      @(posedge clk);
      edges++;
    end
    if (!seen) edges = -1;
    res = {cout, sum};
    @(negedge clk);
    done_after = done;
  endtask

  logic [W:0] res, exp;
  int         edges, busy_n, unstable, done_cnt;
  logic       done_after;
  logic [W-1:0] ra, rb;
  logic       rc;

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'({cout, sum}), 32'd0);
    rst = 1'b0;

    run_op(8'h00, 8'h00, 1'b0, res, edges, busy_n, unstable, done_after);
    check("zero_res", 32'(res), 32'(ref_add(8'h00, 8'h00, 1'b0)));
    check("zero_latency", 32'(edges), 32'(W + 1));
    check("zero_pulse", 32'(done_after), 32'd0);

    run_op(8'hFF, 8'h01, 1'b0, res, edges, busy_n, unstable, done_after);
    check("ff01_res", 32'(res), 32'h100);
    check("ff01_busy", 32'(busy_n), 32'(W));

    run_op(8'hFF, 8'hFF, 1'b1, res, edges, busy_n, unstable, done_after);
    check("ffff1_res", 32'(res), 32'h1FF);
    check("ffff1_stable", 32'(unstable), 32'd0);

    // back-to-back with start held and operands changed during RUN
    @(negedge clk);
    start = 1'b1; a = 8'h5A; b = 8'h3C; cin = 1'b1;
    @(negedge clk);
    a = 8'h11; b = 8'h22; cin = 1'b0;
    edges = -1;
    for (int k = 0; k < 4 * W; k++) begin
      if (done) begin edges = k; break; end
      @(negedge clk);
    end
    check("b2b_first_seen", 32'(edges >= 0), 32'd1);
    check("b2b_first_res", 32'({cout, sum}), 32'h097);
    @(negedge clk);
    check("b2b_no_idle", 32'(busy), 32'd1);
    start = 1'b0;
    edges = -1;
    for (int k = 0; k < 4 * W; k++) begin
      if (done) begin edges = k; break; end
      @(negedge clk);
    end
    check("b2b_second_seen", 32'(edges >= 0), 32'd1);
    check("b2b_second_res", 32'({cout, sum}), 32'h033);

    // reset in the middle of RUN
    @(negedge clk);
    start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_sum", 32'({cout, sum}), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 2 * W; k++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check("midrst_quiet", 32'(done_cnt), 32'd0);
    check("midrst_hold", 32'({cout, sum}), 32'd0);
    run_op(8'h01, 8'h01, 1'b0, res, edges, busy_n, unstable, done_after);
    check("after_rst_res", 32'(res), 32'h002);

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      exp = ref_add(ra, rb, rc);
      run_op(ra, rb, rc, res, edges, busy_n, unstable, done_after);
      check("rand_res", 32'(res), 32'(exp));
      check("rand_latency", 32'(edges), 32'(W + 1));
      check("rand_stable", 32'(unstable), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
